// File: rtl/sobol_bsg.sv
// Sobol-driven bitstream generator: latches a source value and compares it against
// successive RNG words to emit a 2^BITWIDTH-beat unary stream. Optional BSG_ONES_CNT_EN adds oOnes/oDone.
module sobol_bsg #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iSrcValid,
    input  logic [BITWIDTH-1:0] iSrc,
    output logic                oSrcReady,
    input  logic [BITWIDTH-1:0] iRng,
    output logic                oRngEn,
    output logic                oBit,
    output logic                oBitValid,
    input  logic                iBitReady,
    output logic                oLast
`ifdef BSG_ONES_CNT_EN
    ,
    output logic [BITWIDTH:0]   oOnes,
    output logic                oDone
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [BITWIDTH-1:0] ONE = 1;

    state_t              r_state, w_next;
    logic [BITWIDTH-1:0] r_src, r_beatCnt;
    logic                w_run, w_accept, w_bit, w_last, w_load;

    always_ff @(posedge iClk) begin
        if (iRst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Outputs are gated by iRst so the reset cycle itself shows idle values.
    always_comb begin
        w_next    = r_state;
        w_run     = !iRst && (r_state == RUN);
        oSrcReady = !iRst && (r_state == IDLE);
        w_load    = oSrcReady && iSrcValid;
        w_bit     = w_run && (r_src > iRng);
        w_last    = w_run && (r_beatCnt == '1);
        w_accept  = w_run && iBitReady;
        oBitValid = w_run;
        oBit      = w_bit;
        oLast     = w_last;
        oRngEn    = w_accept;
        case (r_state)
            IDLE: if (iSrcValid)           w_next = RUN;
            RUN:  if (w_accept && w_last)  w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_src     <= '0;
            r_beatCnt <= '0;
        end else if (w_load) begin
            r_src     <= iSrc;
            r_beatCnt <= '0;
        end else if (w_accept) begin
            r_beatCnt <= r_beatCnt + ONE;
        end
    end

`ifdef BSG_ONES_CNT_EN
    logic [BITWIDTH:0] r_onesCnt, r_ones, w_onesNext;
    logic              r_done;

    assign w_onesNext = r_onesCnt + {{BITWIDTH{1'b0}}, w_bit};

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_onesCnt <= '0;
            r_ones    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_onesCnt <= '0;
            end else if (w_accept) begin
                r_onesCnt <= w_onesNext;
                if (w_last) begin
                    r_ones <= w_onesNext;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign oOnes = iRst ? '0 : r_ones;
    assign oDone = r_done && !iRst;
`endif

endmodule

// File: tb/tb_sobol_bsg.sv
// Bench for sobol_bsg: Gray-code Sobol RNG model driven by oRngEn, table-driven streams,
// a source scoreboard and hand sequences for back-to-back and mid-run reset.
module tb_sobol_bsg;

    logic       iClk = 1'b0;
    logic       iRst, iSrcValid, iBitReady;
    logic [7:0] iSrc, iRng;
    logic       oSrcReady, oRngEn, oBit, oBitValid, oLast;
`ifdef BSG_ONES_CNT_EN
    logic [8:0] oOnes;
    logic       oDone;
`endif

    sobol_bsg #(.BITWIDTH(8)) dut (
        .iClk(iClk), .iRst(iRst), .iSrcValid(iSrcValid), .iSrc(iSrc),
        .oSrcReady(oSrcReady), .iRng(iRng), .oRngEn(oRngEn), .oBit(oBit),
        .oBitValid(oBitValid), .iBitReady(iBitReady), .oLast(oLast)
`ifdef BSG_ONES_CNT_EN
        , .oOnes(oOnes), .oDone(oDone)
`endif
    );

    always #5 iClk = ~iClk;

    // First-dimension Sobol: bit-reversed Gray code of an index, advanced only by oRngEn.
    logic [7:0] rngIdx = 8'd17;
    logic [7:0] gray;
    assign gray = rngIdx ^ (rngIdx >> 1);
    always_comb for (int b = 0; b < 8; b++) iRng[b] = gray[7-b];
    always @(posedge iClk) if (oRngEn) rngIdx <= rngIdx + 8'd1;

    typedef struct { logic [7:0] src; int exp; } sb_t;
    typedef struct { logic [7:0] src; bit bp; int exp; } vec_t;

    sb_t sbq[$];
    int  nchk = 0, npass = 0;
    int  beats = 0, ones = 0, streams = 0, expAfter = 0;
    bit  chkFirst = 0, chkAfter = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act === req) npass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    endtask

    // Monitor: sampled on the falling edge, so iBitReady here decides the next rising edge.
    always @(negedge iClk) begin
        if (iRst) begin
            beats = 0; ones = 0; chkFirst = 0; chkAfter = 0;
        end else begin
            if (chkFirst) begin
                check("first_valid", oBitValid, 1);
                chkFirst = 0;
            end
`ifdef BSG_ONES_CNT_EN
            check("done_pulse", oDone, chkAfter);
            if (chkAfter) check("ones_reg", oOnes, expAfter);
`endif
            if (chkAfter) begin
                check("ready_after", oSrcReady, 1);
                check("valid_after", oBitValid, 0);
                chkAfter = 0;
            end
            if (oSrcReady && iSrcValid) chkFirst = 1;
            if (oBitValid) begin
                if (sbq.size() == 0) begin
                    check("sb_nonempty", 0, 1);
                end else begin
                    check("bit", oBit, sbq[0].src > iRng);
                    check("last", oLast, beats == 255);
                    check("rng_en", oRngEn, iBitReady);
                    if (iBitReady) begin
                        beats++;
                        ones += oBit;
                        if (beats == 256) begin
                            check("ones_ext", ones, sbq[0].exp);
                            expAfter = sbq[0].exp;
                            void'(sbq.pop_front());
                            beats = 0; ones = 0; chkAfter = 1; streams++;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_streams(input int target, input bit bp, input int budget);
        int t = 0;
        while (streams < target && t < budget) begin
            iBitReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge iClk); #1;
            t++;
        end
        if (streams < target) check("stream_timeout", streams, target);
        iBitReady = 1'b1;
    endtask

    task automatic run_stream(input logic [7:0] s, input int e, input bit bp);
        int start = streams;
        sbq.push_back('{s, e});
        iSrcValid = 1'b1; iSrc = s; iBitReady = 1'b1;
        @(posedge iClk); #1;
        iSrcValid = 1'b0; iSrc = 8'hA5;
        wait_streams(start + 1, bp, 3000);
        repeat (2) @(posedge iClk); #1;
    endtask

    task automatic check_reset_outs(input string name);
        check(name, {oSrcReady, oBitValid, oBit, oLast, oRngEn}, 0);
`ifdef BSG_ONES_CNT_EN
        check({name, "_ones"}, {oOnes, oDone}, 0);
`endif
    endtask

    vec_t tv[4];

    initial begin
        int start, t;
        tv[0] = '{8'd100, 1'b0, 100};
        tv[1] = '{8'd0,   1'b0, 0};
        tv[2] = '{8'd255, 1'b0, 255};
        tv[3] = '{8'd128, 1'b1, 128};

        iRst = 1'b1; iSrcValid = 1'b0; iSrc = 8'd0; iBitReady = 1'b1;
        repeat (2) @(posedge iClk);
        @(negedge iClk) check_reset_outs("reset_outs");
        @(posedge iClk); #1 iRst = 1'b0;
        @(negedge iClk) check("ready_post_reset", oSrcReady, 1);
        @(posedge iClk); #1;

        for (int i = 0; i < 4; i++) run_stream(tv[i].src, tv[i].exp, tv[i].bp);

        // Back-to-back with iSrcValid held; the 200 offered mid-run must not disturb stream 1.
        start = streams;
        sbq.push_back('{8'd37, 37});
        sbq.push_back('{8'd200, 200});
        iSrcValid = 1'b1; iSrc = 8'd37;
        @(posedge iClk); #1 iSrc = 8'd200;
        wait_streams(start + 1, 1'b0, 3000);
        @(posedge iClk); #1 iSrcValid = 1'b0; iSrc = 8'd3;
        wait_streams(start + 2, 1'b0, 3000);
        repeat (2) @(posedge iClk); #1;

        // Reset after 50 accepted beats.
        sbq.push_back('{8'd60, 60});
        iSrcValid = 1'b1; iSrc = 8'd60;
        @(posedge iClk); #1 iSrcValid = 1'b0;
        t = 0;
        while (beats != 50 && t < 500) begin @(posedge iClk); #1; t++; end
        check("beats_before_reset", beats, 50);
        iRst = 1'b1;
        @(negedge iClk) check_reset_outs("midrun_reset_outs");
        sbq.delete();
        @(posedge iClk); #1 iRst = 1'b0;
        @(negedge iClk) begin
            check("ready_after_abort", oSrcReady, 1);
            check("valid_after_abort", oBitValid, 0);
        end
        @(posedge iClk); #1;
        run_stream(8'd60, 60, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/sobol_bsg.md
# sobol_bsg

Sobol-driven bitstream generator: the stage directly downstream of the Sobol RNG. It latches one binary source value and compares it against successive RNG words to emit a unary bitstream of exactly 2^BITWIDTH bits, one per accepted beat. It drives the RNG enable itself, so downstream backpressure stalls the sequence without losing any values. Because one full Sobol period visits every BITWIDTH-bit value exactly once, the stream carries exactly `src` ones whatever phase the RNG starts in.

## Interface
- BITWIDTH, 8, width of the source value, the RNG word and the beat counter; stream length is 2^BITWIDTH.

- iClk  input  1  clock; everything is rising-edge.
- iRst  input  1  synchronous reset, active-high.
- iSrcValid  input  1  source value offered.
- iSrc  input  BITWIDTH  unsigned source value (0..2^BITWIDTH-1).
- oSrcReady  output  1  block can accept a source value.
- iRng  input  BITWIDTH  current Sobol word from the RNG.
- oRngEn  output  1  RNG advance enable, wired to the RNG enable input.
- oBit  output  1  current stream bit.
- oBitValid  output  1  oBit is valid.
- iBitReady  input  1  downstream accepts oBit this cycle.
- oLast  output  1  current beat is the final (2^BITWIDTH-th) beat.
- oOnes  output  BITWIDTH+1  ones count of the finished stream (only with BSG_ONES_CNT_EN).
- oDone  output  1  one-cycle pulse when oOnes is updated (only with BSG_ONES_CNT_EN).

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- IDLE
  - oSrcReady=1, oBitValid=0, oRngEn=0.
  - When iSrcValid=1: latch iSrc into srcReg, clear beatCnt and onesCnt, go to RUN.
- RUN
  - oSrcReady=0, oBitValid=1.
  - oBit = (srcReg > iRng), combinational from srcReg and the live iRng. The comparison is unsigned and strict.
  - A beat is accepted when oBitValid && iBitReady.
  - oRngEn = RUN && iBitReady, so the RNG advances only on accepted beats.
  - On each accepted beat: beatCnt += 1 (BITWIDTH bits, wraps), and onesCnt += oBit.
  - oLast = RUN && (beatCnt == 2^BITWIDTH-1).
  - On an accepted beat while oLast=1, go to IDLE. With BSG_ONES_CNT_EN, also load oOnes with the final count (onesCnt + oBit) and pulse oDone on the next cycle.
- Not accepted (iBitReady=0): beatCnt, onesCnt, srcReg and oBit hold; the RNG is frozen.
- iSrcValid and iSrc are ignored in RUN. The next value can be accepted no earlier than the cycle after the last beat (minimum one IDLE cycle between streams).
- srcReg = 2^BITWIDTH-1 gives 2^BITWIDTH-1 ones. A value of 2^BITWIDTH (probability 1) cannot be represented.

## Timing
- While iRst=1 (evaluated at the clock edge) all registers clear: state=IDLE, srcReg=0, beatCnt=0, onesCnt=0.
- Output values while iRst=1:
  - oSrcReady=0 (gated by iRst).
  - oBitValid=0, oBit=0, oLast=0, oRngEn=0.
  - oOnes=0, oDone=0.
- Reset asserted mid-RUN: the stream aborts at that edge with no oDone and no oLast. After reset deasserts, the block is in IDLE with oSrcReady=1 on the first cycle.
- Source to first bit: source accepted at edge N; oBitValid=1 in cycle N+1.
- Stream duration: exactly 2^BITWIDTH accepted beats. With iBitReady tied high that is 2^BITWIDTH consecutive cycles.
- oDone is high the cycle after the final accepted beat, coincident with IDLE. oOnes holds its value until the next oDone or reset.
- iRng must be the RNG register output. The RNG updates at the edge where oRngEn=1, so the next beat sees the next Sobol word.

## Configuration
- BSG_ONES_CNT_EN defined:
  - onesCnt register, oOnes and oDone are present.
  - Used as a self-check and for unary-to-binary loopback.
- BSG_ONES_CNT_EN undefined:
  - onesCnt logic, oOnes and oDone are removed.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use BITWIDTH=8 with the real Sobol RNG instance, with oRngEn wired to its enable.
- Nominal: iSrc=100, iBitReady=1 → 256 valid beats with oLast on beat 256; 100 ones counted; oOnes=100 with oDone pulse; oSrcReady=1 the following cycle.
- Extremes: iSrc=0 → 256 beats, all zero, oOnes=0. iSrc=255 → 255 ones, oOnes=255.
- Backpressure: iSrc=128, iBitReady toggles pseudo-randomly → oRngEn=0 and oBit, beatCnt held on every stall; still exactly 256 accepted beats with 128 ones.
- Back-to-back: iSrcValid held high with 37 then 200 → second accept occurs the first IDLE cycle after stream 1; oOnes=37, then 200; iSrc changes during RUN are ignored.
- Reset mid-run: iSrc=60, assert iRst at beat 50 → next cycle all outputs at reset values, no oDone; after release, iSrc=60 produces a full 256-beat stream with oOnes=60.
- Compile without BSG_ONES_CNT_EN: repeat the nominal case → identical oBit, oLast, oRngEn traces, checked by an external ones counter (=100).
